mcp3008_responder: RTL
======================

// Module: mcp3008_responder
// PURPOSE
// - Synthesizable SPI-slave model of the MCP3008 10-bit, 8-channel ADC (mode 0,0).
// - Sits opposite the ADC master interface for loopback self-test and board bring-up
//   without the real ADC fitted.
// - Oversamples dclk/cs_n/din on the system clock, decodes the start/SGL/D2..D0 command,
//   then serialises the selected channel word on dout.
// PARAMETERS
// - DW           10  bits per conversion result
// - NCH          8   channels; ch_data packs NCH*DW bits, channel n at [n*DW +: DW]
// - SYNC_STAGES  2   synchroniser depth on dclk, cs_n and din (2..3)
// PORTS
// - clk        in   1       system clock; frequency >= 8x dclk
// - rst_n      in   1       asynchronous, active-low reset
// - dclk       in   1       SPI data clock from the master
// - cs_n       in   1       active-low chip select from the master
// - din        in   1       command bits from the master, sampled on dclk rising edge
// - ch_data    in   NCH*DW  conversion values presented by the bench/CCD path
// - dout       out  1       serial result, changes after a dclk falling edge
// - dout_oe    out  1       1 while a frame is active (drives pad tri-state)
// - conv_valid out  1       1-clk pulse when the command is decoded
// - ch_sel     out  3       channel decoded (D2..D0); held until the next decode
// - sgl_diff   out  1       SGL/DIFF bit decoded; held until the next decode
// - frame_err  out  1       1-clk pulse when cs_n rises before B0 has been driven
// BEHAVIOUR
// - Reset values: dout=0, dout_oe=0, conv_valid=0, ch_sel=0, sgl_diff=0, frame_err=0,
//   state=IDLE, shift register=0, cs_n synchroniser preset to 1.
// - Edge detect: synced dclk rise/fall are 1-clk strobes. Pin edge to dout update
//   latency is SYNC_STAGES+1 clk.
// - IDLE: dout_oe=0, dout=0. Synced cs_n low -> WAIT_START and dout_oe=1.
// - WAIT_START: on each rise with din=0, stay (leading zeros allowed).
//   On a rise with din=1 -> CMD, bit count=0.
// - CMD: 4 rises capture SGL, D2, D1, D0 (MSB first). On the 4th rise, in the same clk:
//   - latch ch_data[ch*DW +: DW] into the shift register;
//   - update ch_sel/sgl_diff; pulse conv_valid.
//   ch_data changes after this point do not affect the frame. Then -> NULL.
// - NULL: next fall drives dout=0 (null bit) -> MSB.
// - MSB: next DW falls drive B9..B0 in order.
//   After B0 -> LSB if MCP3008_LSB_TRAIL_EN is defined, else -> ZERO.
// - LSB: next DW-1 falls drive B1..B9 (B0 not repeated) -> ZERO.
// - ZERO: dout=0 on every later fall until cs_n rises.
// - Synced cs_n high in any state -> IDLE in the next clk; dout=0, dout_oe=0.
//   - frame_err pulses iff the state was CMD, NULL, or MSB with B0 not yet driven.
//   - cs_n rise in the same clk as a dclk edge: cs_n wins and the edge is ignored.
// - Rises in NULL/MSB/LSB/ZERO are ignored; falls in IDLE/WAIT_START/CMD leave dout=0.
// - Reset mid-frame: all outputs return to reset values at once.
//   A new frame needs a cs_n high->low after rst_n deasserts.
// CONFIGURATION
// - MCP3008_LSB_TRAIL_EN defined: after B0, emit B1..B9 LSB-first as the real part does
//   while cs_n stays low.
// - MCP3008_LSB_TRAIL_EN undefined: dout=0 after B0 until cs_n rises.
// TESTING
// - ch0=0x2A5; master sends 1,1,000 then 11 clocks
//   -> dout 0,1010100101; conv_valid x1; ch_sel=0; sgl_diff=1.
// - din=0 for 3 clocks, then 1,0,101; ch5=0x3FF
//   -> null 0 then ten 1s; ch_sel=5; sgl_diff=0; no frame_err.
// - ch0=0x201, 21 clocks after D0
//   -> macro on: 0,1000000001,000000001; macro off: 0,1000000001,000000000.
// - cs_n high after B5 -> frame_err x1, dout_oe=0 within SYNC_STAGES+1 clk;
//   next full frame returns its data correctly.
// - ch3 changed from 0x155 to 0x0AA two clk after the D0 rise
//   -> dout shows 0x155; rst_n low mid-MSB -> all outputs at reset values at once.

Source files
------------

// File: rtl/mcp3008_responder.sv
// mcp3008_responder: SPI mode (0,0) slave model of an MCP3008 10-bit, 8-channel ADC.
// dclk, cs_n and din are oversampled on clk. A start bit followed by
// SGL/D2/D1/D0 selects one channel of ch_data, and that word is sent on dout
// as a null bit followed by the data MSB first.
// Build option: define MCP3008_LSB_TRAIL_EN to repeat B1..B9 LSB-first after
// B0, as the real part does; otherwise dout stays 0 after B0.
module mcp3008_responder #(
  parameter int DW          = 10,
  parameter int NCH         = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dclk,
  input  logic              cs_n,
  input  logic              din,
  input  logic [NCH*DW-1:0] ch_data,
  output logic              dout,
  output logic              dout_oe,
  output logic              conv_valid,
  output logic [2:0]        ch_sel,
  output logic              sgl_diff,
  output logic              frame_err
);

  localparam int IW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_CMD,
    S_NULL,
    S_MSB,
    S_LSB,
    S_ZERO
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] dclk_sync_q, dclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   dclk_prev_q, dclk_prev_d;
  logic                   armed_q, armed_d;
  logic [2:0]             cmd_q, cmd_d;
  logic [1:0]             bcnt_q, bcnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DW-1:0]          shift_q, shift_d;
  logic                   dout_q, dout_d;
  logic                   oe_q, oe_d;
  logic                   conv_q, conv_d;
  logic [2:0]             ch_sel_q, ch_sel_d;
  logic                   sgl_q, sgl_d;
  logic                   ferr_q, ferr_d;

  logic                   dclk_s, cs_s, din_s, sync_ok;
  logic                   rise, fall;
  logic [2:0]             ch_idx;
  logic [DW-1:0]          sel_word;
  logic [IW-1:0]          midx;

  // Synchroniser shift chains and synced dclk edge strobes.
  // fill_q marks when the synchronisers hold real pin samples rather than
  // reset presets, so a cs_n held low through reset is not taken as a frame.
  always_comb begin
    dclk_sync_d = {dclk_sync_q[SYNC_STAGES-2:0], dclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], din};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    dclk_s      = dclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    sync_ok     = fill_q[SYNC_STAGES-1];
    dclk_prev_d = dclk_s;
    rise        = dclk_s & ~dclk_prev_q;
    fall        = ~dclk_s & dclk_prev_q;
  end

  // Channel word selected by the command bits completing on this rise.
  always_comb begin
    ch_idx   = {cmd_q[1:0], din_s};
    sel_word = '0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (ch_idx == 3'(n)) sel_word = ch_data[n*DW +: DW];
    end
    midx = IW'(DW - 1) - idx_q;
  end

  // Frame FSM: next state, shift/index updates and registered outputs.
  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cmd_d    = cmd_q;
    bcnt_d   = bcnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    conv_d   = 1'b0;
    ch_sel_d = ch_sel_q;
    sgl_d    = sgl_q;
    ferr_d   = 1'b0;

    if (cs_s) begin
      // cs_n high overrides any dclk edge seen in the same clk.
      state_d = S_IDLE;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
      ferr_d  = (state_q == S_CMD) || (state_q == S_NULL) || (state_q == S_MSB);
      if (sync_ok) armed_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          dout_d = 1'b0;
          oe_d   = 1'b0;
          if (armed_q) begin
            state_d = S_WAIT_START;
            oe_d    = 1'b1;
            armed_d = 1'b0;
          end
        end
        S_WAIT_START: begin
          if (rise && din_s) begin
            state_d = S_CMD;
            bcnt_d  = '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_d  = {cmd_q[1:0], din_s};
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              sgl_d    = cmd_q[2];
              ch_sel_d = ch_idx;
              shift_d  = sel_word;
              conv_d   = 1'b1;
              state_d  = S_NULL;
            end
          end
        end
        S_NULL: begin
          if (fall) begin
            dout_d  = 1'b0;
            idx_d   = '0;
            state_d = S_MSB;
          end
        end
        S_MSB: begin
          if (fall) begin
            dout_d = shift_q[midx];
            if (idx_q == IW'(DW - 1)) begin
`ifdef MCP3008_LSB_TRAIL_EN
              idx_d   = IW'(1);
              state_d = S_LSB;
`else
              state_d = S_ZERO;
`endif
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        S_LSB: begin
          if (fall) begin
            dout_d = shift_q[idx_q];
            if (idx_q == IW'(DW - 1)) state_d = S_ZERO;
            else                      idx_d   = idx_q + IW'(1);
          end
        end
        S_ZERO: begin
          if (fall) dout_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          dout_d  = 1'b0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; cs_n synchroniser presets to deasserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      fill_q      <= '0;
      dclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cmd_q       <= '0;
      bcnt_q      <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      dout_q      <= 1'b0;
      oe_q        <= 1'b0;
      conv_q      <= 1'b0;
      ch_sel_q    <= '0;
      sgl_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dclk_sync_q <= dclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      fill_q      <= fill_d;
      dclk_prev_q <= dclk_prev_d;
      armed_q     <= armed_d;
      cmd_q       <= cmd_d;
      bcnt_q      <= bcnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      oe_q        <= oe_d;
      conv_q      <= conv_d;
      ch_sel_q    <= ch_sel_d;
      sgl_q       <= sgl_d;
      ferr_q      <= ferr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_oe    = oe_q;
  assign conv_valid = conv_q;
  assign ch_sel     = ch_sel_q;
  assign sgl_diff   = sgl_q;
  assign frame_err  = ferr_q;

endmodule
